// File: rtl/time_glyph_stream_pkg.sv
// Shared types and helpers for the time glyph renderer.
// Holds BCD time layout, FSM encoding and conversion functions.
package time_glyph_stream_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } time_bcd_t;

  localparam int COLON_CODE_DEF = 10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_PIXEL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int nchar(input int show_seconds);
    return (show_seconds != 0) ? 8 : 5;
  endfunction

  function automatic logic [7:0] bin2bcd_60(
    input logic [7:0] v
  );
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 8'd10);
    o = 4'(v % 8'd10);
    return {t, o};
  endfunction

  // One bit per field: {hh, mm, ss} out of range.
  function automatic logic [2:0] field_bad(
    input logic [23:0] b
  );
    return {b[23:16] > 8'd23,
            b[15:8]  > 8'd59,
            b[7:0]   > 8'd59};
  endfunction

  function automatic time_bcd_t bin2time(
    input logic [23:0] b
  );
    logic [2:0] bad;
    time_bcd_t  t;
    bad = field_bad(b);
    {t.h1, t.h0} = bad[2] ? 8'h00 : bin2bcd_60(b[23:16]);
    {t.m1, t.m0} = bad[1] ? 8'h00 : bin2bcd_60(b[15:8]);
    {t.s1, t.s0} = bad[0] ? 8'h00 : bin2bcd_60(b[7:0]);
    return t;
  endfunction

  function automatic bcd_t char_code(
    input logic [2:0] c,
    input time_bcd_t  t,
    input bcd_t       colon
  );
    bcd_t r;
    r = colon;
    unique case (c)
      3'd0: r = t.h1;
      3'd1: r = t.h0;
      3'd3: r = t.m1;
      3'd4: r = t.m0;
      3'd6: r = t.s1;
      3'd7: r = t.s0;
      default: r = colon;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/time_glyph_stream_counter.sv
// BCD hh:mm:ss register with range-checked load and
// one-second tick with full day rollover.
module time_bcd_counter
  import time_glyph_stream_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [23:0] load_time,
  input  logic        tick,
  output time_bcd_t   digits,
  output logic        load_err
);

  time_bcd_t ld;
  time_bcd_t inc;

  assign ld = bin2time(load_time);

  always_comb begin
    inc = digits;
    if (digits.s0 != 4'd9) begin
      inc.s0 = digits.s0 + 4'd1;
    end else begin
      inc.s0 = 4'd0;
      if (digits.s1 != 4'd5) begin
        inc.s1 = digits.s1 + 4'd1;
      end else begin
        inc.s1 = 4'd0;
        if (digits.m0 != 4'd9) begin
          inc.m0 = digits.m0 + 4'd1;
        end else begin
          inc.m0 = 4'd0;
          if (digits.m1 != 4'd5) begin
            inc.m1 = digits.m1 + 4'd1;
          end else begin
            inc.m1 = 4'd0;
            if (digits.h1 == 4'd2 &&
                digits.h0 == 4'd3) begin
              inc.h1 = 4'd0;
              inc.h0 = 4'd0;
            end else if (digits.h0 == 4'd9) begin
              inc.h0 = 4'd0;
              inc.h1 = digits.h1 + 4'd1;
            end else begin
              inc.h0 = digits.h0 + 4'd1;
            end
          end
        end
      end
    end
  end

  // A load in the same cycle as a tick swallows the tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits   <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load_valid &&
                  (field_bad(load_time) != 3'b000);
      if (load_valid) begin
        digits <= ld;
      end else if (tick) begin
        digits <= inc;
      end
    end
  end

endmodule

// File: rtl/time_glyph_stream.sv
// Renders one glyph row of HH:MM[:SS] as a pixel stream.
// Optional alarm compare enabled by TIME_GLYPH_ALARM_EN.
module time_glyph_stream
  import time_glyph_stream_pkg::*;
#(
  parameter int GLYPH_W      = 13,
  parameter int GLYPH_H      = 24,
  parameter int ROM_AW       = 9,
  parameter int PIX_W        = 24,
  parameter int SHOW_SECONDS = 1,
  parameter int COLON_CODE   = COLON_CODE_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  input  logic [23:0]        load_time,
  output logic               load_err,
  input  logic               tick,
  input  logic               render_start,
  input  logic [4:0]         row,
  output logic               busy,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [GLYPH_W-1:0] rom_q,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
`ifdef TIME_GLYPH_ALARM_EN
  input  logic               alarm_set,
  input  logic [23:0]        alarm_time,
  output logic               alarm_hit,
`endif
  output logic               done
);

  localparam int NCH = nchar(SHOW_SECONDS);
  localparam int AW  = ROM_AW + 4;
  localparam int BW  = $clog2(GLYPH_W);

  time_bcd_t          digits;
  time_bcd_t          snap;
  logic [1:0]         state;
  logic [2:0]         c;
  logic [BW-1:0]      beat;
  logic [GLYPH_W-1:0] shreg;
  logic [4:0]         srow;
  logic               first;
  logic               blank;
  logic               row_blank;
  logic               accept;
  logic               last_beat;
  logic               pix_bit;

  time_bcd_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_time  (load_time),
    .tick       (tick),
    .digits     (digits),
    .load_err   (load_err)
  );

  function automatic logic [ROM_AW-1:0] addr_of(
    input logic [2:0] ci,
    input time_bcd_t  t,
    input logic [4:0] r
  );
    return ROM_AW'(
      AW'(char_code(ci, t, 4'(COLON_CODE)))
      * AW'(GLYPH_H) + AW'(r));
  endfunction

  assign busy      = state != ST_IDLE;
  assign pix_valid = state == ST_PIXEL;
  assign done      = state == ST_DONE;
  assign accept    = pix_valid & pix_ready;
  assign last_beat = beat == BW'(GLYPH_W - 1);
  assign row_blank = 32'(row) >= GLYPH_H;

  // First pixel cycle reads the ROM word directly.
  assign pix_bit = blank |
                   (first ? rom_q[GLYPH_W-1]
                          : shreg[GLYPH_W-1]);
  assign pix_data = {PIX_W{pix_bit | ~pix_valid}};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      rom_addr <= '0;
      c        <= '0;
      beat     <= '0;
      shreg    <= '0;
      snap     <= '0;
      srow     <= '0;
      first    <= 1'b0;
      blank    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (render_start) begin
            snap  <= digits;
            srow  <= row;
            c     <= '0;
            blank <= row_blank;
            if (!row_blank) begin
              rom_addr <= addr_of(3'd0, digits, row);
            end
            state <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          first <= 1'b1;
          beat  <= '0;
          state <= ST_PIXEL;
        end
        ST_PIXEL: begin
          if (first) begin
            first <= 1'b0;
            shreg <= accept ? rom_q << 1 : rom_q;
          end else if (accept) begin
            shreg <= shreg << 1;
          end
          if (accept) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              if (c == 3'(NCH - 1)) begin
                state <= ST_DONE;
              end else begin
                c <= c + 3'd1;
                if (!blank) begin
                  rom_addr <= addr_of(c + 3'd1,
                                      snap, srow);
                end
                state <= ST_FETCH;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef TIME_GLYPH_ALARM_EN
  time_bcd_t alarm;
  logic      armed;
  logic      upd_q;

  // upd_q marks the cycle in which fresh digits are visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm     <= '0;
      armed     <= 1'b0;
      upd_q     <= 1'b0;
      alarm_hit <= 1'b0;
    end else begin
      upd_q     <= load_valid | tick;
      alarm_hit <= upd_q & armed & (digits == alarm);
      if (alarm_set) begin
        alarm <= bin2time(alarm_time);
        armed <= (alarm_time != 24'hFFFFFF) &&
                 (field_bad(alarm_time) == 3'b000);
      end
    end
  end
`endif

endmodule

// File: tb/tb_time_glyph_stream.sv
// Randomized bench for time_glyph_stream against a
// seconds-of-day model and a synthetic glyph ROM.
`timescale 1ns/1ps
module tb_time_glyph_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [23:0] load_time;
  logic        tick;
  logic [4:0]  row;
  logic        pix_ready;
  logic        rs1, rs2;

  logic        err1, busy1, pv1, done1;
  logic [8:0]  ra1;
  logic [12:0] rq1;
  logic [23:0] pd1;
  logic        err2, busy2, pv2, done2;
  logic [8:0]  ra2;
  logic [12:0] rq2;
  logic [23:0] pd2;
`ifdef TIME_GLYPH_ALARM_EN
  logic        alarm_set;
  logic [23:0] alarm_time;
  logic        hit1, hit2;
`endif

  int total = 0;
  int bad = 0;
  int tsec = 0;
  logic [8:0] maddr1 = '0;
  logic [8:0] maddr2 = '0;

  always #5 clk = ~clk;

  time_glyph_stream dut1 (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_time(load_time),
    .load_err(err1), .tick(tick),
    .render_start(rs1), .row(row), .busy(busy1),
    .rom_addr(ra1), .rom_q(rq1),
    .pix_valid(pv1), .pix_ready(pix_ready),
    .pix_data(pd1),
`ifdef TIME_GLYPH_ALARM_EN
    .alarm_set(alarm_set), .alarm_time(alarm_time),
    .alarm_hit(hit1),
`endif
    .done(done1)
  );

  time_glyph_stream #(.SHOW_SECONDS(0)) dut2 (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_time(load_time),
    .load_err(err2), .tick(tick),
    .render_start(rs2), .row(row), .busy(busy2),
    .rom_addr(ra2), .rom_q(rq2),
    .pix_valid(pv2), .pix_ready(pix_ready),
    .pix_data(pd2),
`ifdef TIME_GLYPH_ALARM_EN
    .alarm_set(alarm_set), .alarm_time(alarm_time),
    .alarm_hit(hit2),
`endif
    .done(done2)
  );

  function automatic logic [12:0] rom_fn(
    input logic [8:0] a
  );
    logic [12:0] w;
    w = {4'b0, a};
    return (w * 13'd37) ^ (w << 4) ^ 13'h0A5A;
  endfunction

  always @(posedge clk) begin
    rq1 <= rom_fn(ra1);
    rq2 <= rom_fn(ra2);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic int fld(input int v,
                             input int lim);
    return (v > lim) ? 0 : v;
  endfunction

  function automatic int code_of(input int ts,
                                 input int ci);
    int h, m, s;
    int d[8];
    h = ts / 3600;
    m = (ts / 60) % 60;
    s = ts % 60;
    d = '{h / 10, h % 10, 10, m / 10, m % 10,
          10, s / 10, s % 10};
    return d[ci];
  endfunction

  task automatic do_load(input logic [23:0] t,
                         input bit with_tick);
    int h, m, s;
    bit e;
    h = int'(t[23:16]);
    m = int'(t[15:8]);
    s = int'(t[7:0]);
    e = (h > 23) || (m > 59) || (s > 59);
    @(negedge clk);
    load_valid = 1'b1;
    load_time  = t;
    tick       = with_tick;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    tick       = 1'b0;
    tsec = fld(h, 23) * 3600 + fld(m, 59) * 60
         + fld(s, 59);
    @(negedge clk);
    check("load_err", {31'd0, err1}, {31'd0, e});
    @(negedge clk);
    check("load_err_clr", {31'd0, err1}, 32'd0);
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    tsec = (tsec + 1) % 86400;
  endtask

  task automatic render(input bit sel, input int r,
                        input bit rnd,
                        input bit mid_tick,
                        input bit mid_start,
                        input bit chk_lat);
    int ns, code, exp_done, done_cyc;
    int nmis, aidx, amis;
    logic [12:0] word;
    logic [8:0]  ea;
    logic        exp_pix[$];
    logic        got_pix[$];
    logic [8:0]  exp_addr[$];
    logic        v, dn, prev_stall, prev_v;
    logic [23:0] d, prev_d;
    logic [8:0]  a;
    ns = sel ? 5 : 8;
    for (int ci = 0; ci < ns; ci++) begin
      code = code_of(tsec, ci);
      if (r < 24) begin
        ea = 9'(code * 24 + r);
        if (sel) maddr2 = ea;
        else maddr1 = ea;
        word = rom_fn(ea);
      end else begin
        word = '1;
      end
      exp_addr.push_back(sel ? maddr2 : maddr1);
      for (int b = 12; b >= 0; b--)
        exp_pix.push_back(word[b]);
    end
    exp_done = ns * 14 + 1;
    row = 5'(r);
    if (sel) rs2 = 1'b1;
    else rs1 = 1'b1;
    done_cyc = -1;
    prev_stall = 1'b0;
    prev_v = 1'b0;
    prev_d = '0;
    aidx = 0;
    amis = 0;
    nmis = 0;
    for (int cyc = 1; cyc <= 600 && done_cyc < 0;
         cyc++) begin
      @(posedge clk);
      #1;
      rs1 = 1'b0;
      rs2 = 1'b0;
      if (mid_start && cyc == 10) begin
        if (sel) rs2 = 1'b1;
        else rs1 = 1'b1;
        row = 5'd0;
      end
      tick = mid_tick && cyc == 20;
      if (tick) tsec = (tsec + 1) % 86400;
      pix_ready = rnd ? 1'($urandom_range(0, 1))
                      : 1'b1;
      @(negedge clk);
      v  = sel ? pv2 : pv1;
      d  = sel ? pd2 : pd1;
      a  = sel ? ra2 : ra1;
      dn = sel ? done2 : done1;
      if (prev_stall) begin
        check("stall_valid", {31'd0, v}, 32'd1);
        check("stall_data", {8'd0, d}, {8'd0, prev_d});
      end
      if (v && !prev_v) begin
        if (aidx >= exp_addr.size() ||
            a !== exp_addr[aidx]) amis++;
        aidx++;
      end
      if (v && pix_ready) begin
        if (d !== {24{d[0]}}) nmis++;
        got_pix.push_back(d[0]);
      end
      if (dn) done_cyc = cyc;
      prev_stall = v && !pix_ready;
      prev_v = v;
      prev_d = d;
    end
    tick = 1'b0;
    pix_ready = 1'b1;
    check("done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    if (chk_lat)
      check("done_cycle", done_cyc, exp_done);
    check("pix_count", got_pix.size(), exp_pix.size());
    for (int i = 0; i < got_pix.size() &&
                    i < exp_pix.size(); i++)
      if (got_pix[i] !== exp_pix[i]) nmis++;
    check("pix_order", nmis, 0);
    if (aidx != ns) amis++;
    check("rom_addr_seq", amis, 0);
    @(negedge clk);
    check("busy_clr", {31'd0, sel ? busy2 : busy1},
          32'd0);
  endtask

  initial begin
    int nd, nv;
    reset = 1'b1;
    load_valid = 1'b0;
    load_time = '0;
    tick = 1'b0;
    row = '0;
    pix_ready = 1'b1;
    rs1 = 1'b0;
    rs2 = 1'b0;
`ifdef TIME_GLYPH_ALARM_EN
    alarm_set = 1'b0;
    alarm_time = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_valid", {31'd0, pv1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_err", {31'd0, err1}, 32'd0);
    check("rst_addr", {23'd0, ra1}, 32'd0);
    check("rst_pix", {8'd0, pd1}, 32'h00FF_FFFF);

    // rollover through midnight
    do_load(24'h17_3B_3A, 1'b0);
    do_tick();
    do_tick();
    render(0, 0, 0, 0, 0, 1);

    // out-of-range field and load-beats-tick
    do_load(24'h18_3C_05, 1'b0);
    render(0, 11, 0, 0, 0, 0);
    do_load(24'h01_02_03, 1'b1);
    render(0, 7, 0, 0, 0, 0);

    // 12:34:56 row 3
    do_load(24'h0C_22_38, 1'b0);
    render(0, 3, 0, 0, 0, 1);

    // backpressure with a tick mid-render
    for (int k = 0; k < 4; k++) begin
      do_load({8'($urandom_range(0, 30)),
               8'($urandom_range(0, 70)),
               8'($urandom_range(0, 70))}, 1'b0);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++)
        do_tick();
      render(0, int'($urandom_range(0, 23)),
             1, 1, 0, 0);
    end

    // blank row with an ignored restart
    render(0, 30, 0, 0, 1, 1);

    // reset mid-stream
    @(negedge clk);
    row = 5'd4;
    rs1 = 1'b1;
    @(posedge clk);
    #1;
    rs1 = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tsec = 0;
    maddr1 = '0;
    maddr2 = '0;
    nd = 0;
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      if (done1) nd++;
      if (pv1) nv++;
    end
    check("rst_mid_done", nd, 0);
    check("rst_mid_valid", nv, 0);
    check("rst_mid_busy", {31'd0, busy1}, 32'd0);
    check("rst_mid_addr", {23'd0, ra1}, 32'd0);
    render(0, 5, 0, 0, 0, 1);

    // five-character variant
    do_load(24'h09_1E_2A, 1'b0);
    render(1, 2, 0, 0, 0, 1);
    render(1, 17, 1, 0, 0, 0);

`ifdef TIME_GLYPH_ALARM_EN
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tsec = 0;
    alarm_set = 1'b1;
    alarm_time = 24'h00_00_01;
    @(negedge clk);
    alarm_set = 1'b0;
    do_tick();
    nd = 0;
    repeat (6) begin
      @(negedge clk);
      if (hit1) nd++;
    end
    check("alarm_hit", nd, 1);
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
